cache_ctrl_fsm: RTL and testbench
=================================

// Module: cache_ctrl_fsm
// PURPOSE
//  Direct-mapped, write-back, write-allocate controller placed directly upstream of the cache_line array.
//  Accepts CPU word requests and drives per-line try_read/try_write/cache_write plus the address/data buses.
//  On a dirty miss it writes the victim back to main memory, then fills the line and replays the lookup.
//  Holds a shadow tag per line so it can rebuild victim addresses; keeps saturating hit/miss/writeback counters.
// PARAMETERS
//  ADDRESS_WORD_SIZE  32  word-address width; address = {tag, index}
//  INDEX_SIZE         4   line index width; NUM_LINES = 2**INDEX_SIZE
//  TAG_SIZE           28  must equal ADDRESS_WORD_SIZE-INDEX_SIZE (elaboration check)
//  WORD_SIZE          8   data word width
//  STAT_W             16  statistics counter width
// PORTS
//  clk          in   1          clock, rising edge
//  rst_b        in   1          asynchronous reset, active low
//  cpu_req      in   1          request strobe, sampled only in IDLE
//  cpu_we       in   1          1 = write, 0 = read
//  cpu_addr     in   ADDR_W     word address
//  cpu_wdata    in   WORD_SIZE  write data
//  cpu_ready    out  1          one-cycle completion pulse
//  cpu_rdata    out  WORD_SIZE  read data, valid while cpu_ready=1 and held afterwards
//  cpu_busy     out  1          1 in every state except IDLE
//  line_sel     out  INDEX_SIZE selects the cache_line instance (the array demuxes strobes)
//  arr_addr     out  ADDR_W     address to the selected line
//  try_read / try_write / cache_write  out 1 each  strobes to the selected line
//  arr_wdata    out  WORD_SIZE  write/fill data to the selected line
//  line_hit, line_valid, line_dirty  in 1 each  from the selected line (combinational)
//  line_data    in   WORD_SIZE  data_out of the selected line (registered, 1-cycle latency)
//  mem_req      out  1          memory request, held until mem_ack
//  mem_we       out  1          1 = writeback, 0 = fetch
//  mem_addr     out  ADDR_W     memory word address
//  mem_wdata    out  WORD_SIZE  writeback data
//  mem_rdata    in   WORD_SIZE  fetch data, valid with mem_ack
//  mem_ack      in   1          one-cycle completion pulse, arbitrary latency >= 0
//  stat_hits, stat_misses, stat_wbs  out STAT_W  saturating counters
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, counters, shadow tags and latched request = 0; acts immediately, mid-transaction too.
//  Aborted memory transaction on reset: mem_req drops; memory must tolerate this.
//  IDLE: on cpu_req, latch we/addr/wdata -> LOOKUP. Strobes are 0 outside the states that name them.
//  LOOKUP (arr_addr=req addr, line_sel=index):
//   - hit & read: try_read=1, hits++ -> RD_RESP
//   - hit & write: try_write=1, hits++ -> DONE
//   - miss & valid & dirty: misses++ -> WB_READ
//   - miss otherwise: misses++ -> FILL_MEM (read) or FILL_WR (write)
//  Replayed lookups (after a fill) do not increment any counter.
//  RD_RESP: cpu_rdata<=line_data, cpu_ready=1 -> IDLE.   DONE: cpu_ready=1 -> IDLE.
//  WB_READ: arr_addr={shadow_tag[idx], idx}, try_read=1 -> WB_MEM.
//  WB_MEM: mem_req=1, mem_we=1, mem_addr=victim address, mem_wdata=line_data (captured on entry).
//   On mem_ack: wbs++ -> FILL_MEM (read) or FILL_WR (write).
//  FILL_MEM: mem_req=1, mem_we=0, mem_addr=req addr; on mem_ack latch mem_rdata -> FILL_WR.
//  FILL_WR: cache_write=1, arr_wdata = cpu_wdata (write) or fetched word (read); shadow_tag[idx]<=tag -> LOOKUP.
//   The replayed LOOKUP then hits; for a write, this sets dirty in the line.
//  mem_ack outside WB_MEM/FILL_MEM is ignored. mem_ack in the same cycle mem_req first rises is accepted.
//  cpu_req while busy is ignored; there is no queueing.
//  Latency from cycle of acceptance: hit = 2 cycles to cpu_ready.
//   Clean miss (read or write) = hit latency + fill time + 2; dirty miss adds a 1-cycle victim read plus memory time.
//  Counters saturate at all-ones; there is no wrap-around.
// STRUCTURE
//  cache_defs.vh: state encodings, address-split localparams (TAG/INDEX slicing); shared with the array wrapper.
//  Sub-module cache_tag_shadow: NUM_LINES x TAG_SIZE register file, 1 write port, 1 async read port, reset to 0.
//  The FSM, request latches and counters live in this module.
// TESTING
//  Read miss on cold cache, addr=0x15, mem returns 0xA5 after 3 cycles
//   -> one fetch at mem_addr=0x15, cache_write, replay hit, cpu_rdata=0xA5, misses=1, hits=0.
//  Read 0x15 again -> cpu_ready 2 cycles after acceptance, no mem_req, hits=1.
//  Write 0x3C to 0x15 (hit), then read 0x25 (same index, new tag)
//   -> writeback mem_we=1, addr=0x15, data=0x3C; then fetch 0x25; wbs=1.
//  Write miss to clean line, addr=0x07, data=0x11 -> no mem_req, cache_write data 0x11, replay sets line dirty.
//  Assert rst_b low during WB_MEM -> mem_req and all outputs 0 immediately.
//   After release, a lookup of the previous address misses with line_valid=0.
//  Force counters near all-ones with back-to-back hits -> stat_hits holds all-ones; late mem_ack in IDLE is ignored.

Source files
------------

// File: rtl/cache_ctrl_fsm_pkg.sv
// Shared definitions for the direct-mapped write-back cache controller.
// The state encoding is also used by the cache_line array wrapper.
package cache_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StRdResp,
    StDone,
    StWbRead,
    StWbMem,
    StFillMem,
    StFillWr
  } cache_state_e;

  localparam int unsigned DefAddrW  = 32;
  localparam int unsigned DefIndexW = 4;
  localparam int unsigned DefTagW   = DefAddrW - DefIndexW;
  localparam int unsigned DefWordW  = 8;
  localparam int unsigned DefStatW  = 16;

endpackage

// File: rtl/cache_ctrl_fsm_tag_shadow.sv
// Shadow tag store: one tag per cache line, one write port, one async read port.
// Lets the controller rebuild the victim address without reading tags from the array.
module cache_ctrl_fsm_tag_shadow #(
  parameter int unsigned INDEX_SIZE = 4,
  parameter int unsigned TAG_SIZE   = 28
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  we,
  input  logic [INDEX_SIZE-1:0] waddr,
  input  logic [TAG_SIZE-1:0]   wdata,
  input  logic [INDEX_SIZE-1:0] raddr,
  output logic [TAG_SIZE-1:0]   rdata
);

  localparam int unsigned NumLines = 2 ** INDEX_SIZE;

  logic [TAG_SIZE-1:0] tag_q [NumLines];
  logic [TAG_SIZE-1:0] tag_d [NumLines];

  always_comb begin
    tag_d = tag_q;
    if (we) begin
      tag_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NumLines; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q <= tag_d;
    end
  end

  assign rdata = tag_q[raddr];

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped, write-back, write-allocate cache controller sitting in front of
// the cache_line array: lookup, victim writeback, fill and replay, plus statistics.
module cache_ctrl_fsm
  import cache_ctrl_fsm_pkg::*;
#(
  parameter int unsigned ADDRESS_WORD_SIZE = DefAddrW,
  parameter int unsigned INDEX_SIZE        = DefIndexW,
  parameter int unsigned TAG_SIZE          = DefTagW,
  parameter int unsigned WORD_SIZE         = DefWordW,
  parameter int unsigned STAT_W            = DefStatW
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDRESS_WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0]         cpu_wdata,
  output logic                         cpu_ready,
  output logic [WORD_SIZE-1:0]         cpu_rdata,
  output logic                         cpu_busy,
  output logic [INDEX_SIZE-1:0]        line_sel,
  output logic [ADDRESS_WORD_SIZE-1:0] arr_addr,
  output logic                         try_read,
  output logic                         try_write,
  output logic                         cache_write,
  output logic [WORD_SIZE-1:0]         arr_wdata,
  input  logic                         line_hit,
  input  logic                         line_valid,
  input  logic                         line_dirty,
  input  logic [WORD_SIZE-1:0]         line_data,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]         mem_wdata,
  input  logic [WORD_SIZE-1:0]         mem_rdata,
  input  logic                         mem_ack,
  output logic [STAT_W-1:0]            stat_hits,
  output logic [STAT_W-1:0]            stat_misses,
  output logic [STAT_W-1:0]            stat_wbs
);

  if (TAG_SIZE != ADDRESS_WORD_SIZE - INDEX_SIZE) begin : g_bad_tag_size
    $error("TAG_SIZE must equal ADDRESS_WORD_SIZE - INDEX_SIZE");
  end

  localparam logic [STAT_W-1:0] StatOne = STAT_W'(1);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + StatOne;
  endfunction

  cache_state_e                 state_q, state_d;
  logic                         we_q, we_d;
  logic [ADDRESS_WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]         wdata_q, wdata_d;
  logic                         replay_q, replay_d;
  logic [WORD_SIZE-1:0]         fill_q, fill_d;
  logic [WORD_SIZE-1:0]         wb_data_q, wb_data_d;
  logic                         wb_first_q, wb_first_d;
  logic [WORD_SIZE-1:0]         rdata_q, rdata_d;
  logic [STAT_W-1:0]            hits_q, hits_d;
  logic [STAT_W-1:0]            misses_q, misses_d;
  logic [STAT_W-1:0]            wbs_q, wbs_d;

  logic [INDEX_SIZE-1:0]        idx;
  logic [TAG_SIZE-1:0]          req_tag;
  logic [TAG_SIZE-1:0]          victim_tag;
  logic [ADDRESS_WORD_SIZE-1:0] victim_addr;
  logic                         shadow_we;

  assign idx         = addr_q[INDEX_SIZE-1:0];
  assign req_tag     = addr_q[ADDRESS_WORD_SIZE-1:INDEX_SIZE];
  assign victim_addr = {victim_tag, idx};
  assign line_sel    = idx;
  assign cpu_busy    = (state_q != StIdle);

  cache_ctrl_fsm_tag_shadow #(
    .INDEX_SIZE(INDEX_SIZE),
    .TAG_SIZE  (TAG_SIZE)
  ) u_tag_shadow (
    .clk  (clk),
    .rst_b(rst_b),
    .we   (shadow_we),
    .waddr(idx),
    .wdata(req_tag),
    .raddr(idx),
    .rdata(victim_tag)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    replay_d    = replay_q;
    fill_d      = fill_q;
    wb_data_d   = wb_data_q;
    wb_first_d  = wb_first_q;
    rdata_d     = rdata_q;
    hits_d      = hits_q;
    misses_d    = misses_q;
    wbs_d       = wbs_q;
    cpu_ready   = 1'b0;
    cpu_rdata   = rdata_q;
    arr_addr    = addr_q;
    arr_wdata   = '0;
    try_read    = 1'b0;
    try_write   = 1'b0;
    cache_write = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    shadow_we   = 1'b0;

    unique case (state_q)
      StIdle: begin
        replay_d = 1'b0;
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = StLookup;
        end
      end
      StLookup: begin
        arr_wdata = wdata_q;
        if (line_hit) begin
          if (!replay_q) hits_d = sat_inc(hits_q);
          if (we_q) begin
            try_write = 1'b1;
            state_d   = StDone;
          end else begin
            try_read = 1'b1;
            state_d  = StRdResp;
          end
        end else begin
          if (!replay_q) misses_d = sat_inc(misses_q);
          if (line_valid && line_dirty) begin
            state_d = StWbRead;
          end else begin
            state_d = we_q ? StFillWr : StFillMem;
          end
        end
      end
      StRdResp: begin
        cpu_ready = 1'b1;
        cpu_rdata = line_data;
        rdata_d   = line_data;
        state_d   = StIdle;
      end
      StDone: begin
        cpu_ready = 1'b1;
        state_d   = StIdle;
      end
      StWbRead: begin
        arr_addr   = victim_addr;
        try_read   = 1'b1;
        wb_first_d = 1'b1;
        state_d    = StWbMem;
      end
      StWbMem: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = victim_addr;
        // Victim word arrives one cycle after the WB_READ strobe; hold it from then on.
        mem_wdata  = wb_first_q ? line_data : wb_data_q;
        wb_data_d  = mem_wdata;
        wb_first_d = 1'b0;
        if (mem_ack) begin
          wbs_d   = sat_inc(wbs_q);
          state_d = we_q ? StFillWr : StFillMem;
        end
      end
      StFillMem: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) begin
          fill_d  = mem_rdata;
          state_d = StFillWr;
        end
      end
      StFillWr: begin
        cache_write = 1'b1;
        arr_wdata   = we_q ? wdata_q : fill_q;
        shadow_we   = 1'b1;
        replay_d    = 1'b1;
        state_d     = StLookup;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      replay_q   <= 1'b0;
      fill_q     <= '0;
      wb_data_q  <= '0;
      wb_first_q <= 1'b0;
      rdata_q    <= '0;
      hits_q     <= '0;
      misses_q   <= '0;
      wbs_q      <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      replay_q   <= replay_d;
      fill_q     <= fill_d;
      wb_data_q  <= wb_data_d;
      wb_first_q <= wb_first_d;
      rdata_q    <= rdata_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
      wbs_q      <= wbs_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_wbs    = wbs_q;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: behavioural cache_line array and memory, directed
// requests, and queue-based monitors for CPU responses, memory traffic and line fills.
module tb_cache_ctrl_fsm;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int TW = 28;
  localparam int WW = 8;
  localparam int SW = 4;

  logic          clk, rst_b;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [WW-1:0] cpu_wdata;
  logic          cpu_ready, cpu_busy;
  logic [WW-1:0] cpu_rdata;
  logic [IW-1:0] line_sel;
  logic [AW-1:0] arr_addr;
  logic          try_read, try_write, cache_write;
  logic [WW-1:0] arr_wdata;
  logic          line_hit, line_valid, line_dirty;
  logic [WW-1:0] line_data;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata, mem_rdata;
  logic [SW-1:0] stat_hits, stat_misses, stat_wbs;

  cache_ctrl_fsm #(
    .ADDRESS_WORD_SIZE(AW),
    .INDEX_SIZE       (IW),
    .TAG_SIZE         (TW),
    .WORD_SIZE        (WW),
    .STAT_W           (SW)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_busy   (cpu_busy),
    .line_sel   (line_sel),
    .arr_addr   (arr_addr),
    .try_read   (try_read),
    .try_write  (try_write),
    .cache_write(cache_write),
    .arr_wdata  (arr_wdata),
    .line_hit   (line_hit),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_data  (line_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses),
    .stat_wbs   (stat_wbs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  // ---------------- cache_line array model ----------------
  logic          a_v [16];
  logic          a_d [16];
  logic [TW-1:0] a_t [16];
  logic [WW-1:0] a_dat [16];

  assign line_valid = a_v[line_sel];
  assign line_dirty = a_d[line_sel];
  assign line_hit   = a_v[line_sel] && (a_t[line_sel] == arr_addr[AW-1:IW]);

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 16; i++) begin
        a_v[i] <= 1'b0;
        a_d[i] <= 1'b0;
        a_t[i] <= '0;
        a_dat[i] <= '0;
      end
      line_data <= '0;
    end else begin
      if (try_read) line_data <= a_dat[line_sel];
      if (try_write && line_hit) begin
        a_dat[line_sel] <= arr_wdata;
        a_d[line_sel]   <= 1'b1;
      end
      if (cache_write) begin
        a_dat[line_sel] <= arr_wdata;
        a_t[line_sel]   <= arr_addr[AW-1:IW];
        a_v[line_sel]   <= 1'b1;
        a_d[line_sel]   <= 1'b0;
      end
    end
  end

  // ---------------- memory model ----------------
  logic [WW-1:0] mem_store [logic [AW-1:0]];
  int            mem_lat = 1;
  logic          stray = 1'b0;

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return a[WW-1:0] ^ 8'hB0;
  endfunction

  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (stray) begin
        mem_ack = 1'b1;
        mem_rdata = 8'hEE;
        stray = 1'b0;
      end else if (rst_b && mem_req) begin
        if (cnt >= mem_lat) begin
          mem_ack = 1'b1;
          if (mem_we) mem_store[mem_addr] = mem_wdata;
          else mem_rdata = mem_word(mem_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- scoreboard queues and monitor ----------------
  typedef struct {
    logic          is_read;
    logic [WW-1:0] rdata;
    int            accept;
    int            lat;
  } cpu_exp_t;
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [WW-1:0] wdata;
  } mem_exp_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } cw_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  cw_exp_t  cw_q[$];

  initial begin
    cpu_exp_t ce;
    mem_exp_t me;
    cw_exp_t  we_e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_b) continue;
      if (cpu_ready) begin
        if (cpu_q.size() == 0) flag_fail("cpu_ready");
        else begin
          ce = cpu_q.pop_front();
          check("latency", cyc - ce.accept, ce.lat);
          if (ce.is_read) check("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, ce.rdata});
        end
      end
      if (mem_req && mem_ack) begin
        if (mem_q.size() == 0) flag_fail("mem_txn");
        else begin
          me = mem_q.pop_front();
          check("mem_we", {31'h0, mem_we}, {31'h0, me.we});
          check("mem_addr", mem_addr, me.addr);
          if (me.we) check("mem_wdata", {24'h0, mem_wdata}, {24'h0, me.wdata});
        end
      end
      if (cache_write) begin
        if (cw_q.size() == 0) flag_fail("cache_write");
        else begin
          we_e = cw_q.pop_front();
          check("fill_addr", arr_addr, we_e.addr);
          check("fill_sel", {28'h0, line_sel}, {28'h0, we_e.addr[IW-1:0]});
          check("fill_data", {24'h0, arr_wdata}, {24'h0, we_e.data});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (cpu_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (cpu_busy) flag_fail({name, "_timeout"});
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [WW-1:0] wdata,
                        input logic [WW-1:0] exp_rdata, input int exp_lat, input logic chk_cold);
    @(negedge clk);
    wait_idle("pre_req");
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wdata;
    cpu_req = 1'b1;
    cpu_q.push_back('{!we, exp_rdata, cyc, exp_lat});
    @(negedge clk);
    cpu_req = 1'b0;
    check("lookup_addr", arr_addr, addr);
    if (chk_cold) check("cold_valid", {31'h0, line_valid}, 32'h0);
    wait_idle("req");
    if (!we) check("rdata_hold", {24'h0, cpu_rdata}, {24'h0, exp_rdata});
  endtask

  task automatic check_stats(input logic [SW-1:0] h, input logic [SW-1:0] m,
                             input logic [SW-1:0] w);
    check("stat_hits", {28'h0, stat_hits}, {28'h0, h});
    check("stat_misses", {28'h0, stat_misses}, {28'h0, m});
    check("stat_wbs", {28'h0, stat_wbs}, {28'h0, w});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'h0, cpu_busy}, 32'h0);
    check({tag, "_ready"}, {31'h0, cpu_ready}, 32'h0);
    check({tag, "_rdata"}, {24'h0, cpu_rdata}, 32'h0);
    check({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
    check({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, {24'h0, mem_wdata}, 32'h0);
    check({tag, "_strobes"}, {29'h0, try_read, try_write, cache_write}, 32'h0);
    check({tag, "_arr_addr"}, arr_addr, 32'h0);
    check({tag, "_line_sel"}, {28'h0, line_sel}, 32'h0);
    check({tag, "_arr_wdata"}, {24'h0, arr_wdata}, 32'h0);
    check_stats(4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    int n;
    rst_b = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_b = 1'b1;

    // Cold read miss: fetch 0x15 -> 0xA5, fill, replay hit.
    mem_lat = 3;
    mem_q.push_back('{1'b0, 32'h15, 8'h00});
    cw_q.push_back('{32'h15, 8'hA5});
    do_req(1'b0, 32'h15, 8'h00, 8'hA5, 5 + 3, 1'b1);
    check_stats(4'd0, 4'd1, 4'd0);

    do_req(1'b0, 32'h15, 8'h00, 8'hA5, 2, 1'b0);
    check_stats(4'd1, 4'd1, 4'd0);

    do_req(1'b1, 32'h15, 8'h3C, 8'h00, 2, 1'b0);
    check_stats(4'd2, 4'd1, 4'd0);

    // Dirty conflict miss with zero-latency memory (ack in the cycle mem_req rises).
    mem_lat = 0;
    mem_q.push_back('{1'b1, 32'h15, 8'h3C});
    mem_q.push_back('{1'b0, 32'h25, 8'h00});
    cw_q.push_back('{32'h25, 8'h95});
    do_req(1'b0, 32'h25, 8'h00, 8'h95, 7, 1'b0);
    check_stats(4'd2, 4'd2, 4'd1);

    // Write miss to a cold line: no memory traffic, replay marks the line dirty.
    cw_q.push_back('{32'h07, 8'h11});
    do_req(1'b1, 32'h07, 8'h11, 8'h00, 4, 1'b1);
    check("dirty_after_replay", {31'h0, a_d[7]}, 32'h1);
    do_req(1'b0, 32'h07, 8'h00, 8'h11, 2, 1'b0);
    check_stats(4'd3, 4'd3, 4'd1);

    // Dirty line 5, then reset while its writeback is outstanding.
    do_req(1'b1, 32'h25, 8'h77, 8'h00, 2, 1'b0);
    mem_lat = 20;
    @(negedge clk);
    cpu_we = 1'b0;
    cpu_addr = 32'h35;
    cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (!(mem_req && mem_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_wb_mem", {31'h0, mem_req && mem_we}, 32'h1);
    rst_b = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_b = 1'b1;
    mem_lat = 1;

    mem_q.push_back('{1'b0, 32'h25, 8'h00});
    cw_q.push_back('{32'h25, 8'h95});
    do_req(1'b0, 32'h25, 8'h00, 8'h95, 6, 1'b1);
    check_stats(4'd0, 4'd1, 4'd0);

    // Back-to-back hits drive the 4-bit hit counter into saturation.
    for (int i = 0; i < 20; i++) begin
      do_req(1'b0, 32'h25, 8'h00, 8'h95, 2, 1'b0);
    end
    check_stats(4'hF, 4'd1, 4'd0);

    // Stray mem_ack while idle must change nothing.
    @(negedge clk);
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_busy", {31'h0, cpu_busy}, 32'h0);
    check_stats(4'hF, 4'd1, 4'd0);
    do_req(1'b0, 32'h25, 8'h00, 8'h95, 2, 1'b0);
    check_stats(4'hF, 4'd1, 4'd0);

    repeat (3) @(negedge clk);
    check("cpu_q_empty", cpu_q.size(), 32'h0);
    check("mem_q_empty", mem_q.size(), 32'h0);
    check("cw_q_empty", cw_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
